result_uart_tx: RTL and testbench

RESULT_UART_TX -- requirements
Module: result_uart_tx

---
 rtl/result_uart_tx_pkg.sv | 27 ++
 rtl/baud_cnt.sv | 30 +++
 rtl/result_uart_tx.sv | 131 +++++++++++++
 tb/tb_result_uart_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/result_uart_tx_pkg.sv
// Shared types and constants for the classifier-result UART transmitter.
// Also holds the helper that turns a class index into its ASCII character.
package result_uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      DONE
   } state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_Q    = 8'h3F;
   localparam logic [7:0] CR         = 8'h0D;
   localparam logic [7:0] LF         = 8'h0A;

   // Only the class index in the low nibble matters; anything above 9 prints as '?'.
   function automatic logic [7:0] digit_char(input logic [7:0] d);
      if (d[3:0] <= 4'd9) begin
         return ASCII_ZERO + {4'h0, d[3:0]};
      end else begin
         return ASCII_Q;
      end
   endfunction

endpackage

// File: rtl/baud_cnt.sv
// Bit-period divider: counts 0..BAUD_DIV-1 while enabled and flags the last
// cycle of each bit period.
module baud_cnt #(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_bit_tick
);

   localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(BAUD_DIV - 1);

   logic [CntW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_bit_tick = i_en && (r_cnt == LastCnt);

endmodule

// File: rtl/result_uart_tx.sv
// Sends the classifier result as "<digit>\r\n" over an 8N1 UART line, then
// pulses tx_done to clear the classifier.
module result_uart_tx
   import result_uart_tx_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd,
   input  logic [7:0] din,
   output logic       tx,
   output logic       tx_done,
   output logic       busy
);

   state_t     r_state;
   logic       r_rd_q;
   logic       r_armed;
   logic [7:0] r_buf;
   logic [7:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic [1:0] r_byte_cnt;
   logic       r_tx;
   logic       r_tx_done;
   logic       r_busy;

   logic       w_start;
   logic       w_tick;
   logic [1:0] w_next_idx;
   logic [7:0] w_next_byte;

   // r_armed blocks a trigger from an rd level that was already high at reset release.
   assign w_start = rd && !r_rd_q && r_armed && (r_state == IDLE);

   baud_cnt #(
      .BAUD_DIV(BAUD_DIV)
   ) u_baud_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (r_state == IDLE),
      .i_en      (r_state != IDLE),
      .o_bit_tick(w_tick)
   );

   assign w_next_idx = r_byte_cnt + 2'd1;

   always_comb begin
      w_next_byte = LF;
      case (w_next_idx)
         2'd0:    w_next_byte = digit_char(r_buf);
         2'd1:    w_next_byte = CR;
         default: w_next_byte = LF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rd_q     <= 1'b0;
         r_armed    <= 1'b0;
         r_buf      <= '0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_tx       <= 1'b1;
         r_tx_done  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_rd_q  <= rd;
         r_armed <= 1'b1;
         unique case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_buf      <= din;
                  r_shift    <= digit_char(din);
                  r_byte_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= START;
               end
            end
            START: begin
               if (w_tick) begin
                  r_tx      <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_bit_cnt <= '0;
                  r_state   <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_tx    <= r_shift[0];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (r_byte_cnt < 2'd2) begin
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                     r_shift    <= w_next_byte;
                     r_tx       <= 1'b0;
                     r_state    <= START;
                  end else begin
                     r_tx_done <= 1'b1;
                     r_state   <= DONE;
                  end
               end
            end
            DONE: begin
               r_tx_done <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx      = r_tx;
   assign tx_done = r_tx_done;
   assign busy    = r_busy;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with BAUD_DIV=4: decodes each frame and
// checks bit timing, tx_done timing, busy, re-trigger rules and reset abort.
module tb_result_uart_tx;

   logic       clk;
   logic       rst_n;
   logic       rd;
   logic [7:0] din;
   logic       tx;
   logic       tx_done;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   result_uart_tx #(
      .BAUD_DIV(4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd     (rd),
      .din    (din),
      .tx     (tx),
      .tx_done(tx_done),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Watches n cycles in which no message may be sent.
   task automatic idle_watch(input string tag, input int n);
      int lows = 0;
      int dones = 0;
      int busys = 0;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (tx !== 1'b1) lows++;
         if (tx_done !== 1'b0) dones++;
         if (busy !== 1'b0) busys++;
      end
      chk({tag, " idle tx low cycles"}, lows, 0);
      chk({tag, " idle tx_done cycles"}, dones, 0);
      chk({tag, " idle busy cycles"}, busys, 0);
   endtask

   // mode 0: plain message; mode 1: rd re-pulsed and din changed mid-digit;
   // mode 2: reset asserted during the second data bit of the CR frame.
   task automatic send_msg(input logic [7:0] d, input logic [7:0] dig, input int mode,
                           input string tag);
      logic [29:0] fr;
      logic [7:0]  exp_b [3];
      logic [7:0]  dec   [3];
      int          bad = 0;
      int          idle_low = 0;
      int          done_cnt = 0;
      int          done_at = -1;
      int          j;
      int          f;
      int          k;
      logic        b1 = 1'b0;
      logic        b121 = 1'b0;
      logic        b122 = 1'b1;
      exp_b[0] = dig;
      exp_b[1] = 8'h0D;
      exp_b[2] = 8'h0A;
      for (int q = 0; q < 3; q++) begin
         dec[q] = 8'h00;
         fr[10*q] = 1'b0;
         for (int b = 0; b < 8; b++) fr[10*q+1+b] = exp_b[q][b];
         fr[10*q+9] = 1'b1;
      end
      @(negedge clk);
      din = d;
      rd  = 1'b1;
      for (int c = 1; c <= 125; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c <= 120) begin
            j = (c - 1) / 4;
            if (tx !== fr[j]) bad++;
            if ((c - 1) % 4 == 2) begin
               f = j / 10;
               k = j % 10;
               if (k >= 1 && k <= 8) dec[f][k-1] = tx;
            end
         end
         if (tx_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (busy !== 1'b1 && tx !== 1'b1) idle_low++;
         if (c == 1) b1 = busy;
         if (c == 121) b121 = busy;
         if (c == 122) b122 = busy;
         if (mode == 1) begin
            if (c == 8) rd = 1'b0;
            if (c == 12) begin
               rd  = 1'b1;
               din = 8'h03;
            end
         end
         if (mode == 2 && c == 50) begin
            chk({tag, " CR bit1 low before reset"}, tx, 0);
            chk({tag, " bits before reset"}, bad, 0);
            rst_n = 1'b0;
            #1;
            chk({tag, " tx forced high by reset"}, tx, 1);
            chk({tag, " busy cleared by reset"}, busy, 0);
            chk({tag, " tx_done low at reset"}, tx_done, 0);
            for (int r = 0; r < 10; r++) begin
               @(posedge clk);
               @(negedge clk);
               if (tx_done === 1'b1) done_cnt++;
               if (tx !== 1'b1) idle_low++;
            end
            chk({tag, " no tx_done after abort"}, done_cnt, 0);
            chk({tag, " tx high in reset"}, idle_low, 0);
            return;
         end
      end
      chk({tag, " bit-level waveform"}, bad, 0);
      chk({tag, " byte0"}, dec[0], exp_b[0]);
      chk({tag, " byte1"}, dec[1], 8'h0D);
      chk({tag, " byte2"}, dec[2], 8'h0A);
      chk({tag, " tx_done pulse count"}, done_cnt, 1);
      chk({tag, " tx_done cycle"}, done_at, 121);
      chk({tag, " tx low while idle"}, idle_low, 0);
      chk({tag, " busy at start"}, b1, 1);
      chk({tag, " busy at done"}, b121, 1);
      chk({tag, " busy after done"}, b122, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      rd    = 1'b0;
      din   = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset tx", tx, 1);
      chk("reset tx_done", tx_done, 0);
      chk("reset busy", busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      send_msg(8'h07, 8'h37, 0, "d07");
      idle_watch("d07 rd held", 50);
      rd = 1'b0;
      repeat (3) @(negedge clk);

      send_msg(8'h0C, 8'h3F, 0, "d0C");
      rd = 1'b0;
      repeat (3) @(negedge clk);

      send_msg(8'h00, 8'h30, 0, "d00");
      rd = 1'b0;
      repeat (3) @(negedge clk);

      send_msg(8'hF5, 8'h35, 1, "mid");
      idle_watch("mid no requeue", 50);
      rd = 1'b0;
      repeat (3) @(negedge clk);

      send_msg(8'h09, 8'h39, 2, "rst");
      rst_n = 1'b1;
      idle_watch("rd high at release", 20);
      rd = 1'b0;
      repeat (3) @(negedge clk);

      send_msg(8'h02, 8'h32, 0, "post");
      rd = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
